rcv_enrg_trg_multi: RTL and testbench
=====================================

Name: rcv_enrg_trg_multi

Overview:
Parametrised multi-channel receiver for energy-detector trigger primitives.
Each of NCH serial lines carries a frame: start bit, then a WBITS trigger word (MSB first), then an optional odd-parity bit.
Per-channel words are merged into one event by a coincidence window opened by the first completed frame.
The block feeds the event builder's trigger logic, replacing the single-channel, fixed 3-bit receiver.

Parameters:
NCH, 2, number of energy-board serial channels (1..8)
WBITS, 3, trigger word bits per channel (1..16)
PARITY, 1, 1 = frame carries an odd-parity bit after the word; 0 = no parity bit
WIN, 4, coincidence window length in cycles (>=1)

Ports:
Clock  in  1  system clock; all logic on rising edge
Reset  in  1  asynchronous, active-low reset
TReqIn  in  NCH  serial trigger lines, bit c = channel c
Address  in  1  board address; simulation $display tagging only
TrgValid  out  1  one-cycle event strobe; no backpressure
TrgWord  out  NCH*WBITS  channel c word at [c*WBITS +: WBITS]; 0 for channels absent from the event
ChMask  out  NCH  channels that contributed to the event
ParErr  out  NCH  parity failure per contributing channel; always 0 when PARITY=0
Partial  out  1  window timed out before all channels reported
Overlap  out  1  a channel completed a second frame inside the window

Behaviour:
- Reset low: every output, state register, counter and shift register goes to 0 immediately. Frames in progress are lost.
- After reset release, a high TReqIn at the first edge is taken as a start bit.
- Channel receiver states: IDLE, DATA, PAR, DONE.
  - IDLE -> DATA on TReqIn=1 (the start bit).
  - DATA shifts one bit per cycle: word <= {word[WBITS-2:0], TReqIn}. After WBITS bits it goes to PAR if PARITY, else DONE.
  - PAR samples one bit. It checks odd parity over word plus that bit, then goes to DONE.
  - DONE asserts an internal done strobe for one cycle, holds word and perr, and returns to IDLE.
  - A start bit is recognised in IDLE only, so the earliest back-to-back start falls in the cycle after DONE.
  - Frame length is 1+WBITS+PARITY cycles.
- Merge states: IDLE and OPEN. The window counter is width $clog2(WIN+1).
- In IDLE, any done strobe opens the window. On that edge (E0) the block latches those channels' words, sets their mask and parity bits, loads count=1 and enters OPEN.
  - If all NCH channels report at E0, the event emits immediately and the state stays IDLE.
- In OPEN, done strobes on edges E1..E(WIN-1) are latched if the channel's mask bit is clear.
  - If the mask bit is already set, the new frame is dropped, the first word is kept, and Overlap is set.
- Close on full mask at edge Ek: TrgValid is high in the following cycle, with Partial=0.
- Close on timeout (count reaches WIN with mask incomplete): TrgValid is high in the following cycle, with Partial=1.
- A done strobe that coincides with the timeout edge is not merged. It opens a new window on that edge.
- The event fields (TrgWord, ChMask, ParErr, Partial, Overlap) are valid only while TrgValid=1 and are cleared the next cycle.
- Latency with aligned channels: TrgValid in start-bit cycle + WBITS + PARITY + 2.

Decomposition:
- Package rcv_enrg_trg_pkg holds:
  - one-hot state encodings for the receiver and merge FSMs;
  - function frame_len(WBITS, PARITY);
  - function odd_par(vector).
- Sub-module rcv_enrg_trg_chan: a single-channel receiver (ports Clock, Reset, TReqIn, Done, Word, PErr), generated NCH times.
- The merge FSM lives in the top level.

Test Plan:
(All tests use NCH=2, WBITS=3, PARITY=1, WIN=4 unless stated.)
- Aligned: both channels start at cycle 0; ch0 word 101 with parity 1, ch1 word 011 with parity 1. Expect TrgValid only in cycle 6, TrgWord=6'b011101, ChMask=11, ParErr=00, Partial=0, Overlap=0.
- Single channel: only ch1 sends 110 with parity 1, starting at cycle 0. Expect TrgValid in cycle 9, ChMask=10, TrgWord=6'b110000, Partial=1.
- Parity error: ch0 sends 111 with parity 1 and ch1 sends 001 with parity 0. Expect ParErr=01, ch0 word still 111, TrgValid in cycle 6.
- Skew:
  - ch1 starts 3 cycles after ch0: one event in cycle 9, ChMask=11, Partial=0.
  - ch1 starts 4 cycles after ch0: an event in cycle 9 with ChMask=01, Partial=1, then a second event in cycle 13 with ChMask=10, Partial=1.
- Overlap (WIN=8): ch0 sends frames back-to-back, 100 then 011; ch1 is silent. Expect TrgValid in cycle 13, TrgWord[2:0]=100, Overlap=1, Partial=1.
- Reset mid-frame: drive Reset low during cycle 2 of a ch0 frame. Expect all outputs 0 asynchronously and no TrgValid. After release, a new aligned frame decodes exactly as in the first test.

Source files
------------

// File: rtl/rcv_enrg_trg_pkg.sv
// Shared types and helpers for the multi-channel energy-detector trigger receiver.
package rcv_enrg_trg_pkg;

  typedef enum logic [3:0] {
    CH_IDLE = 4'b0001,
    CH_DATA = 4'b0010,
    CH_PAR  = 4'b0100,
    CH_DONE = 4'b1000
  } ch_state_e;

  typedef enum logic [1:0] {
    MG_IDLE = 2'b01,
    MG_OPEN = 2'b10
  } mg_state_e;

  // Widest word plus parity bit the parity helper accepts.
  localparam int unsigned PAR_MAXW = 17;

  function automatic int unsigned frame_len(input int unsigned wbits, input int unsigned parity);
    return 1 + wbits + parity;
  endfunction

  // 1 when the vector holds an odd number of ones.
  function automatic logic odd_par(input logic [PAR_MAXW-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rcv_enrg_trg_chan.sv
// Single-channel frame receiver: start bit, WBITS word MSB first, optional odd parity.
module rcv_enrg_trg_chan
  import rcv_enrg_trg_pkg::*;
#(
  parameter int unsigned WBITS  = 3,
  parameter int unsigned PARITY = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             TReqIn,
  output logic             Done,
  output logic [WBITS-1:0] Word,
  output logic             PErr
);

  localparam int unsigned FLEN = frame_len(WBITS, PARITY);
  localparam int unsigned CW   = $clog2(FLEN);

  ch_state_e        r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WBITS-1:0] r_word, w_word_nxt;
  logic             r_perr, w_perr_nxt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= CH_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CH_IDLE: if (TReqIn) w_state_nxt = CH_DATA;
      CH_DATA: if (r_cnt == CW'(WBITS - 1)) w_state_nxt = (PARITY != 0) ? CH_PAR : CH_DONE;
      CH_PAR:  w_state_nxt = CH_DONE;
      CH_DONE: w_state_nxt = CH_IDLE;
      default: w_state_nxt = CH_IDLE;
    endcase
  end

  // Word and parity error are held from DONE until the next start bit.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_word_nxt = r_word;
    w_perr_nxt = r_perr;
    case (r_state)
      CH_IDLE: begin
        if (TReqIn) begin
          w_cnt_nxt  = '0;
          w_perr_nxt = 1'b0;
        end
      end
      CH_DATA: begin
        w_word_nxt = WBITS'({r_word, TReqIn});
        w_cnt_nxt  = r_cnt + CW'(1);
      end
      CH_PAR: begin
        if (PARITY != 0) w_perr_nxt = ~odd_par(PAR_MAXW'({r_word, TReqIn}));
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_perr <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_word <= w_word_nxt;
      r_perr <= w_perr_nxt;
    end
  end

  assign Done = (r_state == CH_DONE);
  assign Word = r_word;
  assign PErr = r_perr;

endmodule

// File: rtl/rcv_enrg_trg_multi.sv
// NCH-channel trigger receiver; per-channel words merged into one event by a coincidence window.
module rcv_enrg_trg_multi
  import rcv_enrg_trg_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned WBITS  = 3,
  parameter int unsigned PARITY = 1,
  parameter int unsigned WIN    = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NCH-1:0]       TReqIn,
  input  logic                 Address,
  output logic                 TrgValid,
  output logic [NCH*WBITS-1:0] TrgWord,
  output logic [NCH-1:0]       ChMask,
  output logic [NCH-1:0]       ParErr,
  output logic                 Partial,
  output logic                 Overlap
);

  localparam int unsigned CW = $clog2(WIN + 1);
  localparam int unsigned TW = NCH * WBITS;

  logic w_unused;
  assign w_unused = Address;

  logic [NCH-1:0] w_done, w_ch_perr;
  logic [TW-1:0]  w_ch_word;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    rcv_enrg_trg_chan #(.WBITS(WBITS), .PARITY(PARITY)) u_chan (
      .Clock  (Clock),
      .Reset  (Reset),
      .TReqIn (TReqIn[g]),
      .Done   (w_done[g]),
      .Word   (w_ch_word[g*WBITS +: WBITS]),
      .PErr   (w_ch_perr[g])
    );
  end

  mg_state_e      r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_n;
  logic [TW-1:0]  r_word, w_word_n, w_word_m, w_word_f;
  logic [NCH-1:0] r_mask, w_mask_n, w_mask_m, w_new;
  logic [NCH-1:0] r_perr, w_perr_n, w_perr_m, w_perr_f;
  logic           r_ovl, w_ovl_n, w_ovl_m;
  logic           w_full, w_tmo;

  logic           r_valid, w_valid_n;
  logic [TW-1:0]  r_oword, w_oword_n;
  logic [NCH-1:0] r_omask, w_omask_n, r_operr, w_operr_n;
  logic           r_opart, w_opart_n, r_oovl, w_oovl_n;

  // Window contents merged with this cycle's done strobes (_m) or a fresh window from them (_f).
  always_comb begin
    w_new    = w_done & ~r_mask;
    w_mask_m = r_mask | w_new;
    w_ovl_m  = r_ovl | (|(w_done & r_mask));
    w_word_m = r_word;
    w_perr_m = r_perr;
    w_word_f = '0;
    w_perr_f = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_new[c]) begin
        w_word_m[c*WBITS +: WBITS] = w_ch_word[c*WBITS +: WBITS];
        w_perr_m[c]                = w_ch_perr[c];
      end
      if (w_done[c]) begin
        w_word_f[c*WBITS +: WBITS] = w_ch_word[c*WBITS +: WBITS];
        w_perr_f[c]                = w_ch_perr[c];
      end
    end
    w_full = &w_mask_m;
    w_tmo  = (r_cnt == CW'(WIN - 1));
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= MG_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MG_IDLE: if ((|w_done) && !w_full && (WIN > 1)) w_state_nxt = MG_OPEN;
      MG_OPEN: begin
        if (w_full)     w_state_nxt = MG_IDLE;
        else if (w_tmo) w_state_nxt = (|w_done) ? MG_OPEN : MG_IDLE;
      end
      default: w_state_nxt = MG_IDLE;
    endcase
  end

  // Event fields are driven only in the strobe cycle; the window is cleared whenever merging ends.
  always_comb begin
    w_valid_n = 1'b0;
    w_oword_n = '0;
    w_omask_n = '0;
    w_operr_n = '0;
    w_opart_n = 1'b0;
    w_oovl_n  = 1'b0;
    w_word_n  = r_word;
    w_mask_n  = r_mask;
    w_perr_n  = r_perr;
    w_ovl_n   = r_ovl;
    w_cnt_n   = r_cnt;
    case (r_state)
      MG_IDLE: begin
        if (|w_done) begin
          if (w_full || (WIN == 1)) begin
            w_valid_n = 1'b1;
            w_oword_n = w_word_m;
            w_omask_n = w_mask_m;
            w_operr_n = w_perr_m;
            w_opart_n = ~w_full;
            w_oovl_n  = w_ovl_m;
          end else begin
            w_word_n = w_word_m;
            w_mask_n = w_mask_m;
            w_perr_n = w_perr_m;
            w_ovl_n  = w_ovl_m;
            w_cnt_n  = CW'(1);
          end
        end
      end
      MG_OPEN: begin
        if (w_full) begin
          w_valid_n = 1'b1;
          w_oword_n = w_word_m;
          w_omask_n = w_mask_m;
          w_operr_n = w_perr_m;
          w_oovl_n  = w_ovl_m;
          w_word_n  = '0;
          w_mask_n  = '0;
          w_perr_n  = '0;
          w_ovl_n   = 1'b0;
          w_cnt_n   = '0;
        end else if (w_tmo) begin
          w_valid_n = 1'b1;
          w_oword_n = r_word;
          w_omask_n = r_mask;
          w_operr_n = r_perr;
          w_opart_n = 1'b1;
          w_oovl_n  = r_ovl;
          w_word_n  = w_word_f;
          w_mask_n  = w_done;
          w_perr_n  = w_perr_f;
          w_ovl_n   = 1'b0;
          w_cnt_n   = (|w_done) ? CW'(1) : '0;
        end else begin
          w_word_n = w_word_m;
          w_mask_n = w_mask_m;
          w_perr_n = w_perr_m;
          w_ovl_n  = w_ovl_m;
          w_cnt_n  = r_cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt   <= '0;
      r_word  <= '0;
      r_mask  <= '0;
      r_perr  <= '0;
      r_ovl   <= 1'b0;
      r_valid <= 1'b0;
      r_oword <= '0;
      r_omask <= '0;
      r_operr <= '0;
      r_opart <= 1'b0;
      r_oovl  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_n;
      r_word  <= w_word_n;
      r_mask  <= w_mask_n;
      r_perr  <= w_perr_n;
      r_ovl   <= w_ovl_n;
      r_valid <= w_valid_n;
      r_oword <= w_oword_n;
      r_omask <= w_omask_n;
      r_operr <= w_operr_n;
      r_opart <= w_opart_n;
      r_oovl  <= w_oovl_n;
    end
  end

  assign TrgValid = r_valid;
  assign TrgWord  = r_oword;
  assign ChMask   = r_omask;
  assign ParErr   = r_operr;
  assign Partial  = r_opart;
  assign Overlap  = r_oovl;

endmodule

// File: tb/tb_rcv_enrg_trg_multi.sv
// Scoreboard bench: expected events queued with stimulus, checked when TrgValid strobes.
module tb_rcv_enrg_trg_multi;

  logic       Clock, Reset, Address;
  logic [1:0] TReqIn, TReqIn8;
  logic       TrgValid, Partial, Overlap;
  logic [5:0] TrgWord;
  logic [1:0] ChMask, ParErr;
  logic       TrgValid8, Partial8, Overlap8;
  logic [5:0] TrgWord8;
  logic [1:0] ChMask8, ParErr8;

  rcv_enrg_trg_multi #(.NCH(2), .WBITS(3), .PARITY(1), .WIN(4)) u_dut (
    .Clock(Clock), .Reset(Reset), .TReqIn(TReqIn), .Address(Address),
    .TrgValid(TrgValid), .TrgWord(TrgWord), .ChMask(ChMask), .ParErr(ParErr),
    .Partial(Partial), .Overlap(Overlap)
  );

  rcv_enrg_trg_multi #(.NCH(2), .WBITS(3), .PARITY(1), .WIN(8)) u_dut8 (
    .Clock(Clock), .Reset(Reset), .TReqIn(TReqIn8), .Address(Address),
    .TrgValid(TrgValid8), .TrgWord(TrgWord8), .ChMask(ChMask8), .ParErr(ParErr8),
    .Partial(Partial8), .Overlap(Overlap8)
  );

  typedef struct {
    int         cyc;
    logic [5:0] word;
    logic [1:0] mask;
    logic [1:0] perr;
    logic       part;
    logic       ovl;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   t0    = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] frm(input logic [2:0] w, input logic p, input int off);
    logic [63:0] v;
    v = '0;
    v[off]     = 1'b1;
    v[off + 1] = w[2];
    v[off + 2] = w[1];
    v[off + 3] = w[0];
    v[off + 4] = p;
    return v;
  endfunction

  task automatic push(input bit use8, input int c, input logic [5:0] w, input logic [1:0] m,
                      input logic [1:0] pe, input logic pa, input logic ov);
    exp_t e;
    e.cyc = c; e.word = w; e.mask = m; e.perr = pe; e.part = pa; e.ovl = ov;
    if (use8) q8.push_back(e);
    else      q4.push_back(e);
  endtask

  // Bit k of each line is driven during test cycle k; expected cycles are relative to t0.
  task automatic run_test(input logic [63:0] l0, input logic [63:0] l1, input bit use8);
    @(posedge Clock); #1;
    t0 = cyc;
    for (int k = 0; k < 24; k++) begin
      if (use8) TReqIn8 = {l1[k], l0[k]};
      else      TReqIn  = {l1[k], l0[k]};
      @(posedge Clock); #1;
    end
    TReqIn  = '0;
    TReqIn8 = '0;
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);
  endtask

  always @(negedge Clock) begin : mon
    exp_t e;
    if (Reset) begin
      if (TrgValid) begin
        if (q4.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          chk("cycle",   32'(cyc - t0), 32'(e.cyc));
          chk("word",    32'(TrgWord),  32'(e.word));
          chk("mask",    32'(ChMask),   32'(e.mask));
          chk("parerr",  32'(ParErr),   32'(e.perr));
          chk("partial", 32'(Partial),  32'(e.part));
          chk("overlap", 32'(Overlap),  32'(e.ovl));
        end
      end else begin
        chk("idle_clear", 32'({TrgWord, ChMask, ParErr, Partial, Overlap}), 32'd0);
      end
      if (TrgValid8) begin
        if (q8.size() == 0) chk("unexpected_valid8", 32'd1, 32'd0);
        else begin
          e = q8.pop_front();
          chk("cycle8",   32'(cyc - t0), 32'(e.cyc));
          chk("word8",    32'(TrgWord8), 32'(e.word));
          chk("mask8",    32'(ChMask8),  32'(e.mask));
          chk("parerr8",  32'(ParErr8),  32'(e.perr));
          chk("partial8", 32'(Partial8), 32'(e.part));
          chk("overlap8", 32'(Overlap8), 32'(e.ovl));
        end
      end else begin
        chk("idle_clear8", 32'({TrgWord8, ChMask8, ParErr8, Partial8, Overlap8}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset   = 1'b0;
    Address = 1'b0;
    TReqIn  = '0;
    TReqIn8 = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_out",  32'({TrgValid, TrgWord, ChMask, ParErr, Partial, Overlap}), 32'd0);
    chk("reset_out8", 32'({TrgValid8, TrgWord8, ChMask8, ParErr8, Partial8, Overlap8}), 32'd0);
    Reset = 1'b1;

    // aligned channels
    push(0, 6, 6'b011101, 2'b11, 2'b00, 1'b0, 1'b0);
    run_test(frm(3'b101, 1'b1, 0), frm(3'b011, 1'b1, 0), 1'b0);

    // single channel times out
    push(0, 9, 6'b110000, 2'b10, 2'b00, 1'b1, 1'b0);
    run_test(64'd0, frm(3'b110, 1'b1, 0), 1'b0);

    // parity error on ch0
    push(0, 6, 6'b001111, 2'b11, 2'b01, 1'b0, 1'b0);
    run_test(frm(3'b111, 1'b1, 0), frm(3'b001, 1'b0, 0), 1'b0);

    // skew 3: still inside the window
    push(0, 9, 6'b011101, 2'b11, 2'b00, 1'b0, 1'b0);
    run_test(frm(3'b101, 1'b1, 0), frm(3'b011, 1'b1, 3), 1'b0);

    // skew 4: two partial events
    push(0, 9,  6'b000101, 2'b01, 2'b00, 1'b1, 1'b0);
    push(0, 13, 6'b011000, 2'b10, 2'b00, 1'b1, 1'b0);
    run_test(frm(3'b101, 1'b1, 0), frm(3'b011, 1'b1, 4), 1'b0);

    // back-to-back frames on ch0 inside an 8-cycle window
    push(1, 13, 6'b000100, 2'b01, 2'b00, 1'b1, 1'b1);
    run_test(frm(3'b100, 1'b0, 0) | frm(3'b011, 1'b1, 6), 64'd0, 1'b1);

    // reset during cycle 2 of an aligned frame
    @(posedge Clock); #1;
    TReqIn = 2'b11;
    @(posedge Clock); #1;
    TReqIn = 2'b01;
    @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    chk("rst_async", 32'({TrgValid, TrgWord, ChMask, ParErr, Partial, Overlap}), 32'd0);
    TReqIn = '0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    repeat (16) @(posedge Clock);
    #1;
    chk("rst_no_event", 32'(q4.size()), 32'd0);

    push(0, 6, 6'b011101, 2'b11, 2'b00, 1'b0, 1'b0);
    run_test(frm(3'b101, 1'b1, 0), frm(3'b011, 1'b1, 0), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
